prom_loader: RTL and testbench

- Writer side of the 128x36 dual-port pattern memory that the LED pattern player reads on the other port.
- Accepts a byte stream over a valid/ready handshake and packs each group of 5 bytes into one 36-bit word.
- Writes the words to consecutive addresses 0..DEPTH-1 through the memory write port (addr/din/we), then reports done.
- Lets the display pattern be replaced at runtime without rebuilding the init image.

---
 rtl/prom_loader_if.sv | 23 ++
 rtl/prom_loader.sv | 100 ++++++++++
 tb/tb_prom_loader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prom_loader_if.sv
// Byte-stream input and memory write-port bundle for the pattern-memory loader.
// slave = loader side, master = stream source / memory observer side.
interface prom_loader_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 36
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic                  mem_we;

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_addr, mem_din, mem_we
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/prom_loader.sv
// Packs a little-endian byte stream into DATA_WIDTH words and writes them to addresses 0..DEPTH-1.
// Six cycles per word minimum (one per byte plus one write cycle); in_ready is low outside LOAD.
module prom_loader #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 36
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  prom_loader_if.slave        bus,
  output logic                busy,
  output logic                done,
  output logic [ADDR_WIDTH:0] word_count
);

  localparam int BPW   = (DATA_WIDTH + 7) / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(BPW - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t                state;
  logic [IDX_W-1:0]      byte_idx;
  logic [DATA_WIDTH-1:0] din_next;
  logic                  accept;

  assign accept = bus.in_valid && bus.in_ready;

  // Merge the incoming byte into its lane; bits beyond DATA_WIDTH in the last byte fall away.
  always_comb begin
    din_next = bus.mem_din;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (byte_idx == IDX_W'(i / 8)) begin
        din_next[i] = bus.in_data[3'(i % 8)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      byte_idx     <= '0;
      bus.in_ready <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
      bus.mem_we   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      word_count   <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= LOAD;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            bus.mem_addr <= '0;
            word_count   <= '0;
            byte_idx     <= '0;
          end
        end
        LOAD: begin
          // A restart wins over a byte arriving in the same cycle; that byte is dropped.
          if (start) begin
            bus.mem_addr <= '0;
            word_count   <= '0;
            byte_idx     <= '0;
          end else if (accept) begin
            bus.mem_din <= din_next;
            if (byte_idx == LAST_IDX) begin
              state        <= WRITE;
              bus.in_ready <= 1'b0;
              bus.mem_we   <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        WRITE: begin
          word_count <= word_count + 1'b1;
          if (bus.mem_addr == LAST_ADDR) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state        <= LOAD;
            bus.mem_addr <= bus.mem_addr + 1'b1;
            byte_idx     <= '0;
            bus.in_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prom_loader.sv
// Directed bench for prom_loader; expected memory writes are queued at stimulus time
// and a negedge monitor checks each mem_we pulse against the queue.
module tb_prom_loader;

  typedef struct packed {
    logic [6:0]  addr;
    logic [35:0] din;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] word_count;

  prom_loader_if #(.ADDR_WIDTH(7), .DATA_WIDTH(36)) bus ();

  prom_loader #(.ADDR_WIDTH(7), .DATA_WIDTH(36)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  nwr   = 0;
  wr_t expq[$];
  wr_t e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.mem_we === 1'b1) begin
      nwr++;
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=%0d din=%h, required no write", bus.mem_addr, bus.mem_din);
      end else begin
        e = expq.pop_front();
        if (bus.mem_addr !== e.addr || bus.mem_din !== e.din) begin
          bad++;
          $display("FAIL write: got addr=%0d din=%h, required addr=%0d din=%h",
                   bus.mem_addr, bus.mem_din, e.addr, e.din);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [6:0] a, input logic [35:0] d);
    wr_t w;
    w.addr = a;
    w.din  = d;
    expq.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   n;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    bus.in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"},   64'(bus.in_ready), 64'd0);
    chk({tag, "_mem_we"},     64'(bus.mem_we),   64'd0);
    chk({tag, "_mem_addr"},   64'(bus.mem_addr), 64'd0);
    chk({tag, "_mem_din"},    64'(bus.mem_din),  64'd0);
    chk({tag, "_busy"},       64'(busy),         64'd0);
    chk({tag, "_done"},       64'(done),         64'd0);
    chk({tag, "_word_count"}, 64'(word_count),   64'd0);
  endtask

  initial begin
    logic [7:0]  bytes_a [5];
    logic [39:0] pk;
    logic        saw_ready;
    int          c0, c1, nwr0;

    bytes_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5};

    // Reset with a byte offered.
    rst_n        = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    repeat (3) tick();
    check_reset_values("reset");
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    repeat (2) tick();
    chk("idle_in_ready", 64'(bus.in_ready), 64'd0);

    // Byte packing, back-to-back.
    push_exp(7'd0, 36'h5_4433_2211);
    pulse_start();
    chk("start_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 5; k++) send_byte(bytes_a[k]);
    repeat (2) tick();
    chk("pack_word_count", 64'(word_count), 64'd1);
    chk("pack_next_addr",  64'(bus.mem_addr), 64'd1);
    chk("pack_queue",      64'(expq.size()), 64'd0);

    // Same word with 3-cycle gaps between bytes.
    pulse_start();
    chk("restart_word_count", 64'(word_count), 64'd0);
    push_exp(7'd0, 36'h5_4433_2211);
    for (int k = 0; k < 5; k++) begin
      send_byte(bytes_a[k]);
      if (k < 4) begin
        repeat (3) begin
          @(negedge clk);
          chk("gap_in_ready", 64'(bus.in_ready), 64'd1);
          @(posedge clk);
          #1;
        end
      end
    end
    repeat (2) tick();
    chk("gap_word_count", 64'(word_count), 64'd1);
    chk("gap_queue",      64'(expq.size()), 64'd0);

    // Abort after 3 bytes; the byte offered with the second start must be dropped.
    pulse_start();
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h99);
    start        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    tick();
    start        = 1'b0;
    bus.in_valid = 1'b0;
    push_exp(7'd0, 36'h5_0403_0201);
    for (int k = 1; k <= 5; k++) send_byte(8'(k));
    repeat (2) tick();
    chk("abort_word_count", 64'(word_count), 64'd1);
    chk("abort_queue",      64'(expq.size()), 64'd0);

    // Full load of 640 bytes, byte i = i mod 256.
    pulse_start();
    for (int w = 0; w < 128; w++) begin
      for (int k = 0; k < 5; k++) pk[8*k +: 8] = 8'((5 * w + k) % 256);
      push_exp(7'(w), pk[35:0]);
    end
    nwr0 = nwr;
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 640; i++) begin
      send_byte(8'(i % 256));
      if (i == 0) c0 = cyc;
      if (i == 639) c1 = cyc;
    end
    chk("full_byte_span_cycles", 64'(c1 - c0), 64'd766);
    chk("full_last_write_we",    64'(bus.mem_we), 64'd1);
    chk("full_done_before",      64'(done), 64'd0);
    tick();
    chk("full_done",       64'(done), 64'd1);
    chk("full_busy",       64'(busy), 64'd0);
    chk("full_word_count", 64'(word_count), 64'd128);
    chk("full_mem_addr",   64'(bus.mem_addr), 64'd127);
    chk("full_writes",     64'(nwr - nwr0), 64'd128);
    chk("full_queue",      64'(expq.size()), 64'd0);

    // A 641st byte is never accepted.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h80;
    saw_ready    = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.in_ready) saw_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("after_done_in_ready", 64'(saw_ready), 64'd0);
    chk("after_done_writes",   64'(nwr - nwr0), 64'd128);
    chk("after_done_done",     64'(done), 64'd1);

    // Reset mid-word after 10 words.
    pulse_start();
    chk("restart_done_clear", 64'(done), 64'd0);
    chk("restart_busy",       64'(busy), 64'd1);
    for (int w = 0; w < 10; w++) begin
      for (int k = 0; k < 5; k++) pk[8*k +: 8] = 8'(8'hC0 + 5 * w + k);
      push_exp(7'(w), pk[35:0]);
    end
    for (int i = 0; i < 52; i++) send_byte(8'(8'hC0 + i));
    chk("midload_word_count", 64'(word_count), 64'd10);
    chk("midload_queue",      64'(expq.size()), 64'd0);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    push_exp(7'd0, 36'hF_DDCC_BBAA);
    pulse_start();
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    send_byte(8'hEF);
    repeat (2) tick();
    chk("reload_word_count", 64'(word_count), 64'd1);
    chk("reload_queue",      64'(expq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
